// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the LSU memory sequencer: FSM states, Conf field layout, size codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RF,
        ST_REQ,
        ST_WAIT,
        ST_WB,
        ST_DRAIN
    } state_t;

    // Conf_awake layout: [1:0] access size, [2] zero-extend, [3] reserved
    localparam int CONF_SZ_LSB = 0;
    localparam int CONF_ZEXT   = 2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Lane of the common data bus owned by the LSU
    localparam logic [1:0] CDB_LANE_LSU = 2'd2;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Single-ported data-memory bus: request/grant, then one response (read data or write ack).
// Latency: response arrives any number of cycles after the granted request.
// Backpressure: requester holds every request field stable until mem_gnt.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane alignment: misalignment check, store lane packing, load extraction and extension.
// Latency: purely combinational.
// Backpressure: none.
// Ports: size/a/zext describe the access; sdata is store data, rdata raw memory word;
//        outputs misalign, wstrb, wdata (replicated store data) and load_data (extended).
module lsu_mem_ctrl_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  a,
    input  logic        zext,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic        misalign,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] sh;

    always_comb begin
        misalign  = 1'b0;
        wstrb     = 4'b0000;
        wdata     = 32'd0;
        load_data = 32'd0;
        sh        = 32'd0;
        case (size)
            SZ_B: begin
                wstrb     = 4'b0001 << a;
                wdata     = {4{sdata[7:0]}};
                sh        = rdata >> {a, 3'b000};
                load_data = zext ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                misalign  = a[0];
                wstrb     = 4'b0011 << a;
                wdata     = {2{sdata[15:0]}};
                sh        = rdata >> {a[1], 4'b0000};
                load_data = zext ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            SZ_W: begin
                misalign  = (a != 2'b00);
                wstrb     = 4'b1111;
                wdata     = sdata;
                load_data = rdata;
            end
            default: begin
                // size code 3 is not a legal access
                misalign  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequences one issued load/store at a time: RF read, memory req/gnt/rvalid, CDB broadcast.
// Latency: load 3 cycles accept->CDB at zero-wait memory, store 4, exception 1.
// Backpressure: stall_lsuq holds the LSU queue while busy; bus fields held until mem_gnt.
// Ports: clk/rst, flush, awake-stage uop bundle, rf_raddr/rf_rdata read port,
//        mem (bus master side), CDB lane outputs.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ready_awake,
    input  logic [5:0]        Px_awake,
    input  logic [ADDR_W-1:0] Addr_awake,
    input  logic [3:0]        Conf_awake,
    input  logic              RegWr_awake,
    input  logic [5:0]        tag_rob_awake,
    input  logic              has_excp_awake,
    output logic              stall_lsuq,
    output logic [5:0]        rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    lsu_mem_ctrl_if.master    mem,
    output logic              ready_cdb_lsu,
    output logic              RegWr_cdb_lsu,
    output logic [5:0]        Pd_cdb_lsu,
    output logic [DATA_W-1:0] data_cdb_lsu,
    output logic [5:0]        tag_rob_cdb_lsu,
    output logic              excp_cdb_lsu
);

    state_t            state;
    logic [5:0]        cap_px;
    logic [5:0]        cap_tag;
    logic [ADDR_W-1:0] cap_addr;
    logic [2:0]        cap_conf;
    logic              cap_regwr;
    logic              cap_excp;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;

    logic              in_idle;
    logic              in_wb;
    logic [1:0]        al_size;
    logic [1:0]        al_a;
    logic              al_misalign;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;
    logic              uop_excp;
    logic              unused_bits;

    assign in_idle = (state == ST_IDLE);
    assign in_wb   = (state == ST_WB);

    // One aligner serves all three uses: in IDLE it checks the incoming uop,
    // afterwards it works on the captured uop for store packing and load extraction.
    assign al_size = in_idle ? Conf_awake[CONF_SZ_LSB +: 2] : cap_conf[CONF_SZ_LSB +: 2];
    assign al_a    = in_idle ? Addr_awake[1:0] : cap_addr[1:0];

    lsu_mem_ctrl_align u_align (
        .size      (al_size),
        .a         (al_a),
        .zext      (cap_conf[CONF_ZEXT]),
        .rdata     (mem.mem_rdata),
        .sdata     (rf_rdata),
        .misalign  (al_misalign),
        .wstrb     (al_wstrb),
        .wdata     (al_wdata),
        .load_data (al_load)
    );

    assign uop_excp    = has_excp_awake | al_misalign;
    assign unused_bits = ^{Conf_awake[3], CDB_LANE_LSU};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cap_px    <= '0;
            cap_tag   <= '0;
            cap_addr  <= '0;
            cap_conf  <= '0;
            cap_regwr <= 1'b0;
            cap_excp  <= 1'b0;
            cap_data  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready_awake && !flush) begin
                        cap_px    <= Px_awake;
                        cap_tag   <= tag_rob_awake;
                        cap_addr  <= Addr_awake;
                        cap_conf  <= Conf_awake[2:0];
                        cap_regwr <= RegWr_awake;
                        cap_excp  <= uop_excp;
                        cap_data  <= '0;
                        wdata_q   <= '0;
                        wstrb_q   <= '0;
                        if (uop_excp)
                            state <= ST_WB;
                        else if (RegWr_awake)
                            state <= ST_REQ;
                        else
                            state <= ST_RF;
                    end
                end
                ST_RF: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        wdata_q <= al_wdata;
                        wstrb_q <= al_wstrb;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // once granted, a response is owed and must be drained
                    if (mem.mem_gnt)
                        state <= flush ? ST_DRAIN : ST_WAIT;
                    else if (flush)
                        state <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (mem.mem_rvalid) begin
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            cap_data <= cap_regwr ? al_load : '0;
                            state    <= ST_WB;
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mem.mem_rvalid)
                        state <= ST_IDLE;
                end
                ST_WB: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall_lsuq      = !in_idle;
    assign rf_raddr        = (state == ST_RF) ? cap_px : 6'd0;

    assign mem.mem_req     = (state == ST_REQ);
    assign mem.mem_we      = (state == ST_REQ) & ~cap_regwr;
    assign mem.mem_addr    = {cap_addr[ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata   = wdata_q;
    assign mem.mem_wstrb   = wstrb_q;

    assign ready_cdb_lsu   = in_wb;
    assign RegWr_cdb_lsu   = in_wb & cap_regwr & ~cap_excp;
    assign Pd_cdb_lsu      = (in_wb && cap_regwr) ? cap_px : 6'd0;
    assign data_cdb_lsu    = in_wb ? cap_data : '0;
    assign tag_rob_cdb_lsu = in_wb ? cap_tag : 6'd0;
    assign excp_cdb_lsu    = in_wb & cap_excp;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: loads, stores, alignment faults, flush drain, reset.
// Latency: n/a.
// Backpressure: memory model drives gnt/rvalid explicitly per step.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ready_awake = 1'b0;
    logic [5:0]  Px_awake = '0;
    logic [31:0] Addr_awake = '0;
    logic [3:0]  Conf_awake = '0;
    logic        RegWr_awake = 1'b0;
    logic [5:0]  tag_rob_awake = '0;
    logic        has_excp_awake = 1'b0;
    logic        stall_lsuq;
    logic [5:0]  rf_raddr;
    logic [31:0] rf_rdata = '0;
    logic        ready_cdb_lsu;
    logic        RegWr_cdb_lsu;
    logic [5:0]  Pd_cdb_lsu;
    logic [31:0] data_cdb_lsu;
    logic [5:0]  tag_rob_cdb_lsu;
    logic        excp_cdb_lsu;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_ctrl_if mem_if ();

    lsu_mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .ready_awake     (ready_awake),
        .Px_awake        (Px_awake),
        .Addr_awake      (Addr_awake),
        .Conf_awake      (Conf_awake),
        .RegWr_awake     (RegWr_awake),
        .tag_rob_awake   (tag_rob_awake),
        .has_excp_awake  (has_excp_awake),
        .stall_lsuq      (stall_lsuq),
        .rf_raddr        (rf_raddr),
        .rf_rdata        (rf_rdata),
        .mem             (mem_if.master),
        .ready_cdb_lsu   (ready_cdb_lsu),
        .RegWr_cdb_lsu   (RegWr_cdb_lsu),
        .Pd_cdb_lsu      (Pd_cdb_lsu),
        .data_cdb_lsu    (data_cdb_lsu),
        .tag_rob_cdb_lsu (tag_rob_cdb_lsu),
        .excp_cdb_lsu    (excp_cdb_lsu)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] px, input logic [31:0] addr, input logic [3:0] conf,
                         input logic regwr, input logic [5:0] tag, input logic excp);
        Px_awake       = px;
        Addr_awake     = addr;
        Conf_awake     = conf;
        RegWr_awake    = regwr;
        tag_rob_awake  = tag;
        has_excp_awake = excp;
        ready_awake    = 1'b1;
        step();
        ready_awake    = 1'b0;
    endtask

    // Zero-wait load: gnt in the first REQ cycle, rvalid in the next, CDB at T+3.
    task automatic run_load(input string name, input logic [31:0] addr, input logic [3:0] conf,
                            input logic [5:0] px, input logic [5:0] tag,
                            input logic [31:0] rdata, input logic [31:0] exp);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        issue(px, addr, conf, 1'b1, tag, 1'b0);
        chk({name, " req"}, {31'd0, mem_if.mem_req}, 32'd1);
        chk({name, " we"}, {31'd0, mem_if.mem_we}, 32'd0);
        chk({name, " addr"}, mem_if.mem_addr, waddr);
        mem_if.mem_gnt = 1'b1;
        step();
        mem_if.mem_gnt   = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = rdata;
        chk({name, " wait stall"}, {31'd0, stall_lsuq}, 32'd1);
        step();
        mem_if.mem_rvalid = 1'b0;
        chk({name, " cdb vld"}, {31'd0, ready_cdb_lsu}, 32'd1);
        chk({name, " cdb data"}, data_cdb_lsu, exp);
        chk({name, " cdb pd"}, {26'd0, Pd_cdb_lsu}, {26'd0, px});
        chk({name, " cdb regwr"}, {31'd0, RegWr_cdb_lsu}, 32'd1);
        chk({name, " cdb tag"}, {26'd0, tag_rob_cdb_lsu}, {26'd0, tag});
        chk({name, " cdb excp"}, {31'd0, excp_cdb_lsu}, 32'd0);
        step();
        chk({name, " back idle"}, {31'd0, stall_lsuq}, 32'd0);
        chk({name, " cdb drop"}, {31'd0, ready_cdb_lsu}, 32'd0);
    endtask

    initial begin
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = '0;

        // reset state
        step();
        step();
        chk("rst stall", {31'd0, stall_lsuq}, 32'd0);
        chk("rst req", {31'd0, mem_if.mem_req}, 32'd0);
        chk("rst addr", mem_if.mem_addr, 32'd0);
        chk("rst cdb", {31'd0, ready_cdb_lsu}, 32'd0);
        chk("rst raddr", {26'd0, rf_raddr}, 32'd0);
        rst = 1'b0;
        step();

        // word load and byte loads with sign/zero extension
        run_load("ldw", 32'h100, 4'b0010, 6'd12, 6'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        run_load("ldb sx", 32'h103, 4'b0000, 6'd20, 6'd6, 32'h80FFFFFF, 32'hFFFFFF80);
        run_load("ldb zx", 32'h103, 4'b0100, 6'd21, 6'd7, 32'h80FFFFFF, 32'h00000080);
        run_load("ldh sx", 32'h102, 4'b0001, 6'd22, 6'd8, 32'h80011234, 32'hFFFF8001);
        run_load("ldh zx", 32'h102, 4'b0101, 6'd23, 6'd9, 32'h80011234, 32'h00008001);

        // store half at 0x102, grant held off for three cycles
        issue(6'd7, 32'h102, 4'b0001, 1'b0, 6'd9, 1'b0);
        chk("sth rf raddr", {26'd0, rf_raddr}, 32'd7);
        chk("sth rf req", {31'd0, mem_if.mem_req}, 32'd0);
        chk("sth rf stall", {31'd0, stall_lsuq}, 32'd1);
        rf_rdata = 32'h0000ABCD;
        step();
        rf_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            chk("sth req", {31'd0, mem_if.mem_req}, 32'd1);
            chk("sth we", {31'd0, mem_if.mem_we}, 32'd1);
            chk("sth addr", mem_if.mem_addr, 32'h100);
            chk("sth wstrb", {28'd0, mem_if.mem_wstrb}, 32'hC);
            chk("sth wdata", mem_if.mem_wdata, 32'hABCDABCD);
            mem_if.mem_gnt = (i == 3);
            step();
        end
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h12345678;
        chk("sth wait req", {31'd0, mem_if.mem_req}, 32'd0);
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("sth cdb vld", {31'd0, ready_cdb_lsu}, 32'd1);
        chk("sth cdb regwr", {31'd0, RegWr_cdb_lsu}, 32'd0);
        chk("sth cdb pd", {26'd0, Pd_cdb_lsu}, 32'd0);
        chk("sth cdb data", data_cdb_lsu, 32'd0);
        chk("sth cdb tag", {26'd0, tag_rob_cdb_lsu}, 32'd9);
        step();

        // store byte at 0x101, zero-wait memory
        issue(6'd3, 32'h101, 4'b0000, 1'b0, 6'd10, 1'b0);
        rf_rdata = 32'h1234565A;
        step();
        rf_rdata = 32'h0;
        chk("stb wstrb", {28'd0, mem_if.mem_wstrb}, 32'h2);
        chk("stb wdata", mem_if.mem_wdata, 32'h5A5A5A5A);
        mem_if.mem_gnt = 1'b1;
        step();
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("stb cdb vld", {31'd0, ready_cdb_lsu}, 32'd1);
        chk("stb cdb tag", {26'd0, tag_rob_cdb_lsu}, 32'd10);
        step();

        // misaligned word load: no bus access, CDB the next cycle with excp
        issue(6'd3, 32'h101, 4'b0010, 1'b1, 6'd2, 1'b0);
        chk("misal req", {31'd0, mem_if.mem_req}, 32'd0);
        chk("misal cdb vld", {31'd0, ready_cdb_lsu}, 32'd1);
        chk("misal excp", {31'd0, excp_cdb_lsu}, 32'd1);
        chk("misal regwr", {31'd0, RegWr_cdb_lsu}, 32'd0);
        chk("misal tag", {26'd0, tag_rob_cdb_lsu}, 32'd2);
        step();

        // flush in IDLE blocks acceptance
        Px_awake    = 6'd1;
        RegWr_awake = 1'b1;
        Addr_awake  = 32'h0;
        Conf_awake  = 4'b0010;
        ready_awake = 1'b1;
        flush       = 1'b1;
        step();
        ready_awake = 1'b0;
        flush       = 1'b0;
        chk("idle flush stall", {31'd0, stall_lsuq}, 32'd0);

        // flush in WAIT, response two cycles later is drained
        issue(6'd4, 32'h200, 4'b0010, 1'b1, 6'd1, 1'b0);
        mem_if.mem_gnt = 1'b1;
        step();
        mem_if.mem_gnt = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain1 stall", {31'd0, stall_lsuq}, 32'd1);
        chk("drain1 cdb", {31'd0, ready_cdb_lsu}, 32'd0);
        chk("drain1 req", {31'd0, mem_if.mem_req}, 32'd0);
        step();
        chk("drain2 stall", {31'd0, stall_lsuq}, 32'd1);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hCAFEF00D;
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("drain done stall", {31'd0, stall_lsuq}, 32'd0);
        chk("drain done cdb", {31'd0, ready_cdb_lsu}, 32'd0);
        run_load("post flush", 32'h300, 4'b0010, 6'd9, 6'd6, 32'h11223344, 32'h11223344);

        // reset while waiting for the response; a late rvalid is ignored
        issue(6'd5, 32'h404, 4'b0010, 1'b1, 6'd7, 1'b0);
        mem_if.mem_gnt = 1'b1;
        step();
        mem_if.mem_gnt = 1'b0;
        rst = 1'b1;
        step();
        chk("wrst stall", {31'd0, stall_lsuq}, 32'd0);
        chk("wrst addr", mem_if.mem_addr, 32'd0);
        chk("wrst wstrb", {28'd0, mem_if.mem_wstrb}, 32'd0);
        chk("wrst cdb", {31'd0, ready_cdb_lsu}, 32'd0);
        chk("wrst tag", {26'd0, tag_rob_cdb_lsu}, 32'd0);
        rst = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'hFFFFFFFF;
        step();
        mem_if.mem_rvalid = 1'b0;
        chk("late rvalid stall", {31'd0, stall_lsuq}, 32'd0);
        chk("late rvalid cdb", {31'd0, ready_cdb_lsu}, 32'd0);
        step();
        chk("late rvalid cdb2", {31'd0, ready_cdb_lsu}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
